// File: rtl/mem_responder.sv
// mem_responder: boot loader plus instruction/data memories for a single-cycle core.
//
// A byte stream on loadValid/loadByte fills the instruction memory. It starts with
// a header byte N (word count), then N words sent high byte first. The core is
// held in reset (rstUP) until the last word is written, then runs (bootDone).
// Both memories are read combinationally. The data memory is written on the
// clock edge only while the core is running.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset (control state only, memories kept)
//   addressMI    instruction address        -> instruction (IM[addressMI])
//   addressMD    data address               -> dataIN (DM[addressMD])
//   dataOUT, wMD processor write data / write enable
//   loadValid, loadByte, loadReady  boot byte handshake
//   rstUP        processor reset, high until boot completes
//   bootDone     high once the program is loaded and the core is running
module mem_responder (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  addressMI,
   output logic [15:0] instruction,
   input  logic [7:0]  addressMD,
   input  logic [7:0]  dataOUT,
   input  logic        wMD,
   output logic [7:0]  dataIN,
   input  logic        loadValid,
   input  logic [7:0]  loadByte,
   output logic        loadReady,
   output logic        rstUP,
   output logic        bootDone
);

   localparam logic [1:0] HEADER  = 2'd0;
   localparam logic [1:0] LOAD_HI = 2'd1;
   localparam logic [1:0] LOAD_LO = 2'd2;
   localparam logic [1:0] RUN     = 2'd3;

   logic [15:0] im [0:255];
   logic [7:0]  dm [0:255];

   logic [1:0]  state;
   logic [1:0]  stateNext;
   logic [7:0]  wordCount;
   logic [7:0]  wordIndex;
   logic [7:0]  wordIndexInc;
   logic [7:0]  hiByte;
   logic        accept;

   // A program holds at most 255 words, so the index reaches the count
   // before it could wrap.
   assign accept       = loadValid && loadReady;
   assign wordIndexInc = wordIndex + 8'd1;

   assign instruction = im[addressMI];
   assign dataIN      = dm[addressMD];

   always_comb begin
      stateNext = state;
      if (accept) begin
         case (state)
            HEADER:  stateNext = (loadByte == 8'd0) ? RUN : LOAD_HI;
            LOAD_HI: stateNext = LOAD_LO;
            LOAD_LO: stateNext = (wordIndexInc == wordCount) ? RUN : LOAD_HI;
            default: stateNext = state;
         endcase
      end
   end

   // Control state; the status outputs are registered decodes of the next state
   // so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HEADER;
         wordIndex <= 8'd0;
         wordCount <= 8'd0;
         hiByte    <= 8'd0;
         loadReady <= 1'b1;
         rstUP     <= 1'b1;
         bootDone  <= 1'b0;
      end else begin
         state     <= stateNext;
         loadReady <= (stateNext != RUN);
         rstUP     <= (stateNext != RUN);
         bootDone  <= (stateNext == RUN);
         if (accept) begin
            case (state)
               HEADER: begin
                  wordCount <= loadByte;
                  wordIndex <= 8'd0;
               end
               LOAD_HI: hiByte    <= loadByte;
               LOAD_LO: wordIndex <= wordIndexInc;
               default: ;
            endcase
         end
      end
   end

   // Memories are never cleared; reset only suppresses the write in its cycle.
   always_ff @(posedge clk) begin
      if (!rst && accept && (state == LOAD_LO))
         im[wordIndex] <= {hiByte, loadByte};
   end

   always_ff @(posedge clk) begin
      if (!rst && wMD && !rstUP)
         dm[addressMD] <= dataOUT;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a per-cycle vector table covering the
// basic boot, run-time data memory access and reset behaviour, followed by
// hand-written sequences for a gapped boot stream and a mid-load reset.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  addressMI;
   logic [15:0] instruction;
   logic [7:0]  addressMD;
   logic [7:0]  dataOUT;
   logic        wMD;
   logic [7:0]  dataIN;
   logic        loadValid;
   logic [7:0]  loadByte;
   logic        loadReady;
   logic        rstUP;
   logic        bootDone;

   int nChecks = 0;
   int nFails  = 0;

   always #5 clk = ~clk;

   mem_responder dut (
      .clk(clk), .rst(rst),
      .addressMI(addressMI), .instruction(instruction),
      .addressMD(addressMD), .dataOUT(dataOUT), .wMD(wMD), .dataIN(dataIN),
      .loadValid(loadValid), .loadByte(loadByte), .loadReady(loadReady),
      .rstUP(rstUP), .bootDone(bootDone)
   );

   typedef struct {
      logic        r;
      logic        lv;
      logic [7:0]  lb;
      logic        w;
      logic [7:0]  aMD;
      logic [7:0]  dOut;
      logic [7:0]  aMI;
      logic        expLr;
      logic        expRu;
      logic        expBd;
      logic        chkI;
      logic [15:0] expI;
      logic        chkD;
      logic [7:0]  expD;
   } vec_t;

   vec_t vecs [17];

   function automatic vec_t mk(input logic r, lv, input logic [7:0] lb,
                               input logic w, input logic [7:0] aMD, dOut, aMI,
                               input logic lr, ru, bd,
                               input logic chkI, input logic [15:0] expI,
                               input logic chkD, input logic [7:0] expD);
      vec_t v;
      v.r = r; v.lv = lv; v.lb = lb; v.w = w; v.aMD = aMD; v.dOut = dOut; v.aMI = aMI;
      v.expLr = lr; v.expRu = ru; v.expBd = bd;
      v.chkI = chkI; v.expI = expI; v.chkD = chkD; v.expD = expD;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs mid-cycle; outputs are sampled 1 ns later,
   // well away from the rising edge.
   task automatic setIn(input logic r, lv, input logic [7:0] lb,
                        input logic w, input logic [7:0] aMD, dOut, aMI);
      @(negedge clk);
      rst = r; loadValid = lv; loadByte = lb; wMD = w;
      addressMD = aMD; dataOUT = dOut; addressMI = aMI;
      #1;
   endtask

   task automatic checkCtl(input string tag, input logic lr, ru, bd);
      check({tag, " loadReady"}, {15'd0, loadReady}, {15'd0, lr});
      check({tag, " rstUP"},     {15'd0, rstUP},     {15'd0, ru});
      check({tag, " bootDone"},  {15'd0, bootDone},  {15'd0, bd});
   endtask

   logic [7:0] stream [7];

   initial begin
      rst = 1'b1; loadValid = 1'b0; loadByte = 8'h00; wMD = 1'b0;
      addressMD = 8'h00; dataOUT = 8'h00; addressMI = 8'h00;

      //          r  lv lb     w  aMD    dOut   aMI    lr ru bd chkI expI      chkD expD
      vecs[0]  = mk(0, 0, 8'h00, 0, 8'd0,  8'h00, 8'd0, 1, 1, 0, 0, 16'h0000, 0, 8'h00);
      vecs[1]  = mk(0, 1, 8'h02, 0, 8'd0,  8'h00, 8'd0, 1, 1, 0, 0, 16'h0000, 0, 8'h00);
      vecs[2]  = mk(0, 1, 8'h12, 0, 8'd0,  8'h00, 8'd0, 1, 1, 0, 0, 16'h0000, 0, 8'h00);
      vecs[3]  = mk(0, 1, 8'h34, 0, 8'd0,  8'h00, 8'd0, 1, 1, 0, 0, 16'h0000, 0, 8'h00);
      vecs[4]  = mk(0, 1, 8'hAB, 0, 8'd0,  8'h00, 8'd0, 1, 1, 0, 1, 16'h1234, 0, 8'h00);
      vecs[5]  = mk(0, 1, 8'hCD, 0, 8'd0,  8'h00, 8'd1, 1, 1, 0, 0, 16'h0000, 0, 8'h00);
      vecs[6]  = mk(0, 1, 8'h77, 0, 8'd0,  8'h00, 8'd1, 0, 0, 1, 1, 16'hABCD, 0, 8'h00);
      vecs[7]  = mk(0, 1, 8'hEE, 0, 8'd0,  8'h00, 8'd0, 0, 0, 1, 1, 16'h1234, 0, 8'h00);
      vecs[8]  = mk(0, 0, 8'h00, 1, 8'd10, 8'h11, 8'd0, 0, 0, 1, 0, 16'h0000, 0, 8'h00);
      vecs[9]  = mk(0, 0, 8'h00, 1, 8'd10, 8'h5A, 8'd0, 0, 0, 1, 0, 16'h0000, 1, 8'h11);
      vecs[10] = mk(0, 1, 8'h99, 0, 8'd10, 8'h00, 8'd1, 0, 0, 1, 1, 16'hABCD, 1, 8'h5A);
      vecs[11] = mk(1, 1, 8'h00, 1, 8'd10, 8'h99, 8'd0, 0, 0, 1, 0, 16'h0000, 1, 8'h5A);
      vecs[12] = mk(0, 0, 8'h00, 1, 8'd10, 8'h33, 8'd0, 1, 1, 0, 1, 16'h1234, 1, 8'h5A);
      vecs[13] = mk(0, 0, 8'h00, 0, 8'd10, 8'h00, 8'd1, 1, 1, 0, 1, 16'hABCD, 1, 8'h5A);
      vecs[14] = mk(0, 1, 8'h00, 0, 8'd10, 8'h00, 8'd0, 1, 1, 0, 0, 16'h0000, 0, 8'h00);
      vecs[15] = mk(0, 0, 8'h00, 0, 8'd10, 8'h00, 8'd0, 0, 0, 1, 1, 16'h1234, 1, 8'h5A);
      vecs[16] = mk(0, 0, 8'h00, 0, 8'd10, 8'h00, 8'd1, 0, 0, 1, 1, 16'hABCD, 0, 8'h00);

      setIn(1, 0, 8'h00, 0, 8'd0, 8'h00, 8'd0);
      for (int i = 0; i < 17; i++) begin
         setIn(vecs[i].r, vecs[i].lv, vecs[i].lb, vecs[i].w,
               vecs[i].aMD, vecs[i].dOut, vecs[i].aMI);
         checkCtl($sformatf("vec%0d", i), vecs[i].expLr, vecs[i].expRu, vecs[i].expBd);
         if (vecs[i].chkI)
            check($sformatf("vec%0d instruction", i), instruction, vecs[i].expI);
         if (vecs[i].chkD)
            check($sformatf("vec%0d dataIN", i), {8'd0, dataIN}, {8'd0, vecs[i].expD});
      end

      // Gapped boot: each valid byte is preceded by an idle cycle carrying a
      // decoy byte that must not be taken.
      stream[0] = 8'h03; stream[1] = 8'h11; stream[2] = 8'h22; stream[3] = 8'h33;
      stream[4] = 8'h44; stream[5] = 8'h55; stream[6] = 8'h66;
      setIn(1, 0, 8'h00, 0, 8'd0, 8'h00, 8'd0);
      for (int i = 0; i < 7; i++) begin
         setIn(0, 0, ~stream[i], 0, 8'd0, 8'h00, 8'd0);
         checkCtl($sformatf("gap%0d idle", i), 1, 1, 0);
         setIn(0, 1, stream[i], 0, 8'd0, 8'h00, 8'd0);
         check($sformatf("gap%0d rstUP", i), {15'd0, rstUP}, 16'd1);
      end
      setIn(0, 0, 8'h00, 0, 8'd0, 8'h00, 8'd0);
      checkCtl("gap done", 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         setIn(0, 0, 8'h00, 0, 8'd0, 8'h00, 8'(i));
         check($sformatf("gap IM[%0d]", i), instruction, {stream[2*i+1], stream[2*i+2]});
      end

      // Mid-load reset after header 03 and one word, with a byte offered on
      // the reset cycle, then a one-word reload over IM[0].
      setIn(1, 0, 8'h00, 0, 8'd0, 8'h00, 8'd0);
      setIn(0, 1, 8'h03, 0, 8'd0, 8'h00, 8'd0);
      setIn(0, 1, 8'hDE, 0, 8'd0, 8'h00, 8'd0);
      setIn(0, 1, 8'hAD, 0, 8'd0, 8'h00, 8'd0);
      setIn(1, 1, 8'h12, 0, 8'd0, 8'h00, 8'd0);
      setIn(0, 0, 8'h00, 0, 8'd0, 8'h00, 8'd0);
      checkCtl("midrst", 1, 1, 0);
      check("midrst IM[0] kept", instruction, 16'hDEAD);
      setIn(0, 0, 8'h00, 0, 8'd0, 8'h00, 8'd1);
      check("midrst IM[1] kept", instruction, 16'h3344);
      setIn(0, 1, 8'h01, 0, 8'd0, 8'h00, 8'd0);
      setIn(0, 1, 8'hFF, 0, 8'd0, 8'h00, 8'd0);
      setIn(0, 1, 8'h00, 0, 8'd0, 8'h00, 8'd0);
      check("reload old word before edge", instruction, 16'hDEAD);
      check("reload rstUP before edge", {15'd0, rstUP}, 16'd1);
      setIn(0, 0, 8'h00, 0, 8'd0, 8'h00, 8'd0);
      checkCtl("reload run", 0, 0, 1);
      check("reload IM[0]", instruction, 16'hFF00);
      setIn(0, 1, 8'h42, 0, 8'd0, 8'h00, 8'd0);
      setIn(0, 1, 8'h43, 0, 8'd0, 8'h00, 8'd0);
      checkCtl("run drop", 0, 0, 1);
      check("run drop IM[0]", instruction, 16'hFF00);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL provide port addressMI, input, 8 bits: instruction address from the processor.
REQ-004 SHALL provide port instruction, output, 16 bits: instruction word at addressMI.
REQ-005 SHALL provide port addressMD, input, 8 bits: data-memory address from the processor.
REQ-006 SHALL provide port dataOUT, input, 8 bits: processor write data.
REQ-007 SHALL provide port wMD, input, 1 bit: processor data-memory write enable.
REQ-008 SHALL provide port dataIN, output, 8 bits: read data returned to the processor.
REQ-009 SHALL provide port loadValid, input, 1 bit: boot byte on loadByte is valid.
REQ-010 SHALL provide port loadByte, input, 8 bits: boot stream byte.
REQ-011 SHALL provide port loadReady, output, 1 bit: block accepts a boot byte this cycle.
REQ-012 SHALL provide port rstUP, output, 1 bit: processor reset, high until boot completes.
REQ-013 SHALL provide port bootDone, output, 1 bit: program loaded, processor running.

Function
REQ-014 SHALL contain instruction memory IM of 256 x 16 bits and data memory DM of 256 x 8 bits.
REQ-015 SHALL drive instruction = IM[addressMI] combinationally (zero-cycle read) to suit the single-cycle core.
REQ-016 SHALL drive dataIN = DM[addressMD] combinationally.
REQ-017 SHALL write DM[addressMD] <= dataOUT at the clock edge when wMD=1 and rstUP=0; SHALL ignore wMD while rstUP=1.
REQ-018 Same-cycle read and write of one DM address: dataIN SHALL show the old value that cycle and the new value from the next cycle.
REQ-019 SHALL accept a boot byte only on a cycle where loadValid=1 and loadReady=1; loadByte is ignored at all other times.
REQ-020 SHALL implement FSM states HEADER, LOAD_HI, LOAD_LO, RUN.
REQ-021 In HEADER, an accepted byte N SHALL be latched into an 8-bit word count and the word index cleared to 0; N=0 SHALL go to RUN, otherwise to LOAD_HI.
REQ-022 In LOAD_HI, an accepted byte SHALL be held as the upper 8 bits, and the FSM SHALL go to LOAD_LO.
REQ-023 In LOAD_LO, an accepted byte SHALL complete the word; the block SHALL write IM[index] <= {hi, byte} and increment index. When the new index equals N, the FSM SHALL go to RUN; otherwise it SHALL go to LOAD_HI.
REQ-024 loadReady SHALL be 1 in HEADER, LOAD_HI and LOAD_LO, and 0 in RUN; bytes offered in RUN SHALL be dropped.
REQ-025 rstUP SHALL be 1 in every state except RUN; bootDone SHALL be 1 only in RUN; both are registered state decodes.
REQ-026 The first cycle with rstUP=0 SHALL be the cycle after the edge that enters RUN; IM writes SHALL be complete by then.
REQ-027 Maximum program is 255 words (indices 0..254); index SHALL never wrap; IM words not loaded SHALL retain prior contents.
REQ-028 While the FSM is not in RUN, an IM read at the index being written SHALL return the old word until the write edge.
REQ-029 The FSM SHALL remain in RUN until rst; no self re-boot.

Reset
REQ-030 rst=1 SHALL force state HEADER, index 0, count 0, held byte 0, loadReady=1, rstUP=1, bootDone=0 on the next edge, from any state including mid-load.
REQ-031 rst SHALL NOT clear IM or DM contents; words written before a mid-load reset remain.
REQ-032 rst SHALL take priority over a simultaneous accepted boot byte or wMD write (the byte and the write are discarded).

Verification
REQ-033 The bench SHALL stream 02,12,34,AB,CD with loadValid held at 1: response SHALL be IM[0]=1234 and IM[1]=ABCD, rstUP falling 5 cycles after the first accept, and loadReady=0 thereafter.
REQ-034 The bench SHALL send header byte 00: response SHALL be bootDone=1 and rstUP=0 on the cycle after the accept, with IM unchanged.
REQ-035 The bench SHALL toggle loadValid during a 3-word load: no byte SHALL be lost or duplicated, and IM[0..2] SHALL match the stream.
REQ-036 In RUN, the bench SHALL set wMD=1, addressMD=10, dataOUT=5A: response SHALL be dataIN=old value that cycle and 5A the next cycle; the same stimulus with rstUP=1 SHALL leave DM[10] unchanged.
REQ-037 The bench SHALL assert rst after header 03 and one word: response SHALL be a return to HEADER with IM[0] kept; a reload of 01,FF,00 SHALL then give IM[0]=FF00 and RUN.
REQ-038 The bench SHALL offer bytes in RUN: IM SHALL be unchanged and loadReady SHALL stay 0.
